// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: CPU memory commands, access
// sizes, arbiter FSM states and the alignment rule.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        DMC_NONE  = 2'b00,
        DMC_LOAD  = 2'b01,
        DMC_STORE = 2'b10
    } dmc_e;

    typedef enum logic [1:0] {
        LM_WORD = 2'b00,
        LM_HALF = 2'b01,
        LM_BYTE = 2'b10
    } lm_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CPU_RD  = 2'b01,
        ST_HOST_RD = 2'b10
    } state_e;

    localparam int WAIT_W = 4;

    // Reserved access size 11 behaves as a word access.
    function automatic logic isMisaligned(input logic [1:0] mode, input logic [1:0] off);
        case (mode)
            LM_HALF: return off[0];
            LM_BYTE: return 1'b0;
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_lane.sv
// Byte-lane steering for the data RAM: store byte-enables and replicated write
// data, plus load lane selection with sign/zero extension.
module dmem_lane
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  stMode_i,
    input  logic [1:0]  stOff_i,
    input  logic [31:0] stData_i,
    input  logic [1:0]  ldMode_i,
    input  logic [1:0]  ldOff_i,
    input  logic        ldSigned_i,
    input  logic [31:0] ramData_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [15:0] halfVal;
    logic [7:0]  byteVal;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = stData_i;
        case (stMode_i)
            LM_HALF: begin
                be_o    = 4'b0011 << {stOff_i[1], 1'b0};
                wdata_o = {2{stData_i[15:0]}};
            end
            LM_BYTE: begin
                be_o    = 4'b0001 << stOff_i;
                wdata_o = {4{stData_i[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        halfVal = ldOff_i[1] ? ramData_i[31:16] : ramData_i[15:0];
        byteVal = ramData_i[8*ldOff_i +: 8];
        rdata_o = ramData_i;
        case (ldMode_i)
            LM_HALF: rdata_o = {{16{ldSigned_i & halfVal[15]}}, halfVal};
            LM_BYTE: rdata_o = {{24{ldSigned_i & byteVal[7]}}, byteVal};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the MIPS MEM stage and the host
// bridge, with a bounded-wait guarantee for the host.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 12,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        dmc_mem,
    input  logic [1:0]        loadmode_mem,
    input  logic              memsigned_mem,
    input  logic [ADDR_W+1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    output logic              cpu_align_err,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic [31:0]       host_rdata,
    output logic              host_ack,
    output logic              ram_en,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(HOST_MAX_WAIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]        ldMode_q, ldMode_d;
    logic [1:0]        ldOff_q, ldOff_d;
    logic              ldSigned_q, ldSigned_d;

    logic        cpuReq, cpuIsLoad, cpuMisaligned, hostForce, cpuWins, hostWins;
    logic [3:0]  laneBe;
    logic [31:0] laneWdata, laneRdata;

    // Qualifying requests with rst_n keeps every output at zero while in reset.
    assign cpuReq        = rst_n && (dmc_mem == DMC_LOAD || dmc_mem == DMC_STORE);
    assign cpuIsLoad     = dmc_mem == DMC_LOAD;
    assign cpuMisaligned = isMisaligned(loadmode_mem, cpu_addr[1:0]);
    assign hostForce     = host_req && (waitCnt_q == MaxWait);
    assign cpuWins       = cpuReq && !hostForce;
    assign hostWins      = rst_n && host_req && !cpuWins;

    dmem_lane uLane (
        .stMode_i   (loadmode_mem),
        .stOff_i    (cpu_addr[1:0]),
        .stData_i   (cpu_wdata),
        .ldMode_i   (ldMode_q),
        .ldOff_i    (ldOff_q),
        .ldSigned_i (ldSigned_q),
        .ramData_i  (ram_rdata),
        .be_o       (laneBe),
        .wdata_o    (laneWdata),
        .rdata_o    (laneRdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= '0;
            ldMode_q   <= '0;
            ldOff_q    <= '0;
            ldSigned_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            ldMode_q   <= ldMode_d;
            ldOff_q    <= ldOff_d;
            ldSigned_q <= ldSigned_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        waitCnt_d     = waitCnt_q;
        ldMode_d      = ldMode_q;
        ldOff_d       = ldOff_q;
        ldSigned_d    = ldSigned_q;
        cpu_rdata     = '0;
        cpu_rvalid    = 1'b0;
        cpu_stall     = 1'b0;
        cpu_align_err = 1'b0;
        host_rdata    = '0;
        host_ack      = 1'b0;
        ram_en        = 1'b0;
        ram_be        = 4'b0000;
        ram_addr      = '0;
        ram_wdata     = '0;

        if (!host_req) waitCnt_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (cpuWins) begin
                    if (host_req && waitCnt_q != MaxWait) waitCnt_d = waitCnt_q + 1'b1;
                    if (cpuMisaligned) begin
                        cpu_align_err = 1'b1;
                        cpu_rvalid    = cpuIsLoad;
                    end else if (cpuIsLoad) begin
                        ram_en     = 1'b1;
                        ram_addr   = cpu_addr[ADDR_W+1:2];
                        cpu_stall  = 1'b1;
                        ldMode_d   = loadmode_mem;
                        ldOff_d    = cpu_addr[1:0];
                        ldSigned_d = memsigned_mem;
                        state_d    = ST_CPU_RD;
                    end else begin
                        ram_en    = 1'b1;
                        ram_be    = laneBe;
                        ram_addr  = cpu_addr[ADDR_W+1:2];
                        ram_wdata = laneWdata;
                    end
                end else if (hostWins) begin
                    waitCnt_d = '0;
                    cpu_stall = cpuReq;
                    ram_en    = 1'b1;
                    ram_addr  = host_addr;
                    if (host_we) begin
                        ram_be    = 4'b1111;
                        ram_wdata = host_wdata;
                        host_ack  = 1'b1;
                    end else begin
                        state_d = ST_HOST_RD;
                    end
                end
            end
            ST_CPU_RD: begin
                cpu_rdata  = laneRdata;
                cpu_rvalid = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_HOST_RD: begin
                host_rdata = ram_rdata;
                host_ack   = 1'b1;
                cpu_stall  = cpuReq;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter: directed scenarios followed
// by random CPU/host traffic scored against a transaction-level memory model.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int AW2    = ADDR_W + 2;
    localparam int MAXW   = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        dmc_mem = '0;
    logic [1:0]        loadmode_mem = '0;
    logic              memsigned_mem = 1'b0;
    logic [AW2-1:0]    cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              cpu_rvalid, cpu_stall, cpu_align_err;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [31:0]       host_wdata = '0;
    logic [31:0]       host_rdata;
    logic              host_ack;
    logic              ram_en;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .HOST_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dmc_mem(dmc_mem), .loadmode_mem(loadmode_mem), .memsigned_mem(memsigned_mem),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .cpu_align_err(cpu_align_err),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .ram_en(ram_en), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] initWord(input int i);
        if (i == 1) return 32'h80FF7F01;
        if (i == 5) return 32'h12345678;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Synchronous single-port RAM; contents are loaded on the first clock edge.
    logic [31:0] ramMem [0:DEPTH-1];
    logic        ramReady = 1'b0;
    always @(posedge clk) begin
        if (!ramReady) begin
            for (int i = 0; i < DEPTH; i++) ramMem[i] <= initWord(i);
            ramReady <= 1'b1;
        end else if (ram_en) begin
            if (ram_be == 4'b0000) ram_rdata <= ramMem[ram_addr];
            else for (int k = 0; k < 4; k++)
                if (ram_be[k]) ramMem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
    end

    // Reference model: expected memory image plus the arbiter's pending work.
    logic [31:0] refMem [0:DEPTH-1];
    int   phase = 0;
    int   wc = 0;
    int   svWord, svOff, svNb, svHost;
    logic svSgn;
    logic lastStall = 1'b0;
    logic lastAck = 1'b0;
    logic lastAckSeen = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] mode);
        if (mode == 2'b01) return 2;
        if (mode == 2'b10) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] extractLoad(input logic [31:0] word, input int off, input int nb, input logic sgn);
        longint v, span;
        span = longint'(1) << (8 * nb);
        v = (longint'(word) >> (8 * off)) % span;
        if (sgn && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic modelCheck();
        logic        cpuReq, isLoad, mis, force_;
        logic        eEn, eStall, eRvalid, eErr, eAck;
        logic [3:0]  eBe;
        logic [31:0] eAddr, eWdata, eRdata, eHrdata;
        int          off, wordA, nb;
        eEn = 0; eStall = 0; eRvalid = 0; eErr = 0; eAck = 0;
        eBe = 0; eAddr = 0; eWdata = 0; eRdata = 0; eHrdata = 0;
        cpuReq = (dmc_mem == 2'b01) || (dmc_mem == 2'b10);
        isLoad = dmc_mem == 2'b01;
        off    = int'(cpu_addr[1:0]);
        wordA  = int'(cpu_addr >> 2);
        nb     = sizeBytes(loadmode_mem);
        mis    = (off % nb) != 0;
        if (phase == 1) begin
            eRvalid = 1;
            eRdata  = extractLoad(refMem[svWord], svOff, svNb, svSgn);
            phase   = 0;
        end else if (phase == 2) begin
            eAck    = 1;
            eHrdata = refMem[svHost];
            eStall  = cpuReq;
            phase   = 0;
        end else begin
            force_ = host_req && (wc == MAXW);
            if (cpuReq && !force_) begin
                if (host_req && wc < MAXW) wc++;
                if (mis) begin
                    eErr = 1;
                    eRvalid = isLoad;
                end else if (isLoad) begin
                    eEn = 1; eAddr = 32'(wordA); eStall = 1; phase = 1;
                    svWord = wordA; svOff = off; svNb = nb; svSgn = memsigned_mem;
                end else begin
                    eEn = 1; eAddr = 32'(wordA);
                    eBe = 4'(((1 << nb) - 1) << off);
                    if (nb == 4) eWdata = cpu_wdata;
                    else if (nb == 2) eWdata = (cpu_wdata & 32'hFFFF) * 32'h0001_0001;
                    else eWdata = (cpu_wdata & 32'hFF) * 32'h0101_0101;
                    for (int i = 0; i < nb; i++)
                        refMem[wordA][8*(off+i) +: 8] = 8'((cpu_wdata >> (8 * i)) & 32'hFF);
                end
            end else if (host_req) begin
                wc = 0; eStall = cpuReq; eEn = 1; eAddr = 32'(host_addr);
                if (host_we) begin
                    eBe = 4'hF; eWdata = host_wdata; eAck = 1;
                    refMem[host_addr] = host_wdata;
                end else begin
                    phase = 2; svHost = int'(host_addr);
                end
            end
        end
        if (!host_req) wc = 0;

        checkOutput("ram_en", ram_en, eEn);
        checkOutput("cpu_stall", cpu_stall, eStall);
        checkOutput("cpu_rvalid", cpu_rvalid, eRvalid);
        checkOutput("cpu_align_err", cpu_align_err, eErr);
        checkOutput("host_ack", host_ack, eAck);
        if (eEn) begin
            checkOutput("ram_be", ram_be, eBe);
            checkOutput("ram_addr", ram_addr, eAddr);
        end
        if (eBe != 0) checkOutput("ram_wdata", ram_wdata, eWdata);
        if (eRvalid) checkOutput("cpu_rdata", cpu_rdata, eRdata);
        if (eAck) checkOutput("host_rdata", host_rdata, eHrdata);
        lastStall   = eStall;
        lastAck     = eAck;
        lastAckSeen = host_ack;
    endtask

    task automatic applyStimulus(input logic [1:0] dmc, input logic [1:0] mode, input logic sgn,
                                 input int addr, input logic [31:0] wd, input logic hreq,
                                 input logic hwe, input int haddr, input logic [31:0] hwd);
        if (host_req && !hreq) checkOutput("hostReqDropBeforeAck", {31'b0, lastAckSeen}, 32'd1);
        dmc_mem = dmc; loadmode_mem = mode; memsigned_mem = sgn;
        cpu_addr = AW2'(addr); cpu_wdata = wd;
        host_req = hreq; host_we = hwe; host_addr = ADDR_W'(haddr); host_wdata = hwd;
    endtask

    task automatic settle();
        #3;
        modelCheck();
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Ctl"}, {27'b0, cpu_rvalid, cpu_stall, cpu_align_err, host_ack, ram_en}, 32'd0);
        checkOutput({tag, "Be"}, ram_be, 32'd0);
        checkOutput({tag, "CpuRdata"}, cpu_rdata, 32'd0);
        checkOutput({tag, "HostRdata"}, host_rdata, 32'd0);
        checkOutput({tag, "RamAddr"}, ram_addr, 32'd0);
        checkOutput({tag, "RamWdata"}, ram_wdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  nDmc, nMode;
        logic        nSgn, nReq, nWe;
        logic [31:0] nWd, nHwd;
        int          nAddr, nHaddr, nb;

        for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);

        #2;
        checkAllZero("reset");
        dmc_mem = 2'b10; cpu_addr = AW2'(4); host_req = 1'b1; host_we = 1'b1;
        #1;
        checkAllZero("resetBusy");
        dmc_mem = 2'b00; cpu_addr = '0; host_req = 1'b0; host_we = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Signed byte load from byte 2 of word 0x80FF7F01.
        applyStimulus(2'b01, 2'b10, 1'b1, 32'h006, 0, 0, 0, 0, 0);
        settle();
        checkOutput("byteLdStall", cpu_stall, 32'd1);
        nextEdge();
        settle();
        checkOutput("byteLdRvalid", cpu_rvalid, 32'd1);
        checkOutput("byteLdRdata", cpu_rdata, 32'hFFFFFFFF);
        nextEdge();

        applyStimulus(2'b10, 2'b01, 1'b0, 32'h002, 32'h0000BEEF, 0, 0, 0, 0);
        settle();
        checkOutput("halfStBe", ram_be, 32'b1100);
        checkOutput("halfStWdata", ram_wdata, 32'hBEEFBEEF);
        checkOutput("halfStStall", cpu_stall, 32'd0);
        nextEdge();

        applyStimulus(2'b00, 2'b00, 1'b0, 0, 0, 1, 0, 5, 0);
        settle();
        checkOutput("hostRdGrantAck", host_ack, 32'd0);
        nextEdge();
        settle();
        checkOutput("hostRdAck", host_ack, 32'd1);
        checkOutput("hostRdData", host_rdata, 32'h12345678);
        nextEdge();
        applyStimulus(2'b00, 2'b00, 1'b0, 0, 0, 0, 0, 0, 0);
        settle();
        nextEdge();

        // Back-to-back CPU stores against a held host write.
        applyStimulus(2'b10, 2'b00, 1'b0, 32'h010, 32'hA5A50010, 1, 1, 7, 32'hCAFE0007);
        for (int c = 1; c <= 5; c++) begin
            settle();
            checkOutput($sformatf("starveAck%0d", c), host_ack, 32'(c == 5));
            checkOutput($sformatf("starveStall%0d", c), cpu_stall, 32'(c == 5));
            nextEdge();
        end
        applyStimulus(2'b10, 2'b00, 1'b0, 32'h010, 32'hA5A50010, 0, 0, 0, 0);
        settle();
        checkOutput("starveResumeStall", cpu_stall, 32'd0);
        nextEdge();

        applyStimulus(2'b01, 2'b00, 1'b0, 32'h001, 0, 0, 0, 0, 0);
        settle();
        checkOutput("misErr", cpu_align_err, 32'd1);
        checkOutput("misRvalid", cpu_rvalid, 32'd1);
        checkOutput("misRdata", cpu_rdata, 32'd0);
        checkOutput("misRamEn", ram_en, 32'd0);
        nextEdge();

        // Reset asserted while the load data return is pending.
        applyStimulus(2'b01, 2'b00, 1'b0, 32'h008, 0, 0, 0, 0, 0);
        settle();
        nextEdge();
        rst_n = 1'b0;
        #1;
        checkAllZero("midRst");
        phase = 0; wc = 0; lastStall = 0; lastAck = 0;
        dmc_mem = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b0, 0, 0, 1, 1, 9, 32'h0BADF00D);
        settle();
        checkOutput("postRstHostAck", host_ack, 32'd1);
        checkOutput("postRstRvalid", cpu_rvalid, 32'd0);
        nextEdge();
        applyStimulus(2'b00, 2'b00, 1'b0, 0, 0, 0, 0, 0, 0);
        settle();
        nextEdge();

        for (int n = 0; n < 3000; n++) begin
            nDmc = dmc_mem; nMode = loadmode_mem; nSgn = memsigned_mem;
            nAddr = int'(cpu_addr); nWd = cpu_wdata;
            nReq = host_req; nWe = host_we; nHaddr = int'(host_addr); nHwd = host_wdata;
            if (!lastStall) begin
                nDmc  = 2'($urandom_range(0, 3));
                nMode = 2'($urandom_range(0, 3));
                nSgn  = 1'($urandom_range(0, 1));
                nb    = sizeBytes(nMode);
                nAddr = 4 * $urandom_range(0, 15);
                if ($urandom_range(0, 4) == 0) nAddr += $urandom_range(0, 3);
                else nAddr += nb * $urandom_range(0, 4 / nb - 1);
                nWd = $urandom;
            end
            if (!host_req || lastAck) begin
                nReq   = ($urandom_range(0, 2) == 0);
                nWe    = 1'($urandom_range(0, 1));
                nHaddr = $urandom_range(0, 15);
                nHwd   = $urandom;
            end
            applyStimulus(nDmc, nMode, nSgn, nAddr, nWd, nReq, nWe, nHaddr, nHwd);
            settle();
            nextEdge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
